lcd_nibble_tx: RTL



---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_cycle_timer.sv | 27 ++
 rtl/lcd_nibble_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the HD44780 4-bit interface.
package lcd_pkg;

  // Clock and HD44780 delay constants, in CLK cycles at FREQ.
  localparam int FREQ   = 50_000_000;
  localparam int t1_uS  = FREQ / 1_000_000;
  localparam int t10us  = 10   * t1_uS;
  localparam int t53us  = 53   * t1_uS;
  localparam int t100us = 100  * t1_uS;
  localparam int t3ms   = 3000 * t1_uS;
  localparam int t4_1ms = 4100 * t1_uS;

  // {RS, D7..D4} command word and post-command delay widths.
  localparam int LCD_CMD_W   = 5;
  localparam int LCD_DELAY_W = 21;
  localparam int LCD_RS_BIT  = 4;
  localparam int LCD_PHASE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_t;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter. After loading value V (V >= 1), o_expired is high
// in the V-th cycle of counting, so a state lasts exactly V clock edges.
module lcd_cycle_timer
  import lcd_pkg::*;
#(
  parameter int W = LCD_PHASE_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge i_clk) begin
    if (i_rst)                         r_cnt <= '0;
    else if (i_load)                   r_cnt <= i_value;
    else if (i_en && (r_cnt != '0))    r_cnt <= r_cnt - W'(1);
  end

  assign o_expired = (r_cnt <= W'(1));

endmodule

// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit physical-layer transmitter: drives {RS,D7..D4} and E with
// setup / pulse-width / hold timing, waits a caller delay, pulses commandDone.
// Optional macro LCD_NIBBLE_TX_BUSY_EN adds a 'busy' output (FSM != IDLE).
module lcd_nibble_tx #(
  parameter int FREQ      = 50_000_000,
  parameter int SETUP_CYC = 2,
  parameter int PW_CYC    = 12,
  parameter int HOLD_CYC  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          sendCommand,
  input  logic [lcd_pkg::LCD_CMD_W-1:0]   command,
  input  logic [lcd_pkg::LCD_DELAY_W-1:0] commandDelay,
`ifdef LCD_NIBBLE_TX_BUSY_EN
  output logic                          busy,
`endif
  output logic                          commandDone,
  output logic [lcd_pkg::LCD_CMD_W-1:0]   LCD_D,
  output logic                          LCD_E
);

  import lcd_pkg::*;

  // Phase counter is 8 bits; reject unusable timing at elaboration.
  if (FREQ < 1 || SETUP_CYC < 1 || SETUP_CYC > 255 || PW_CYC < 1 ||
      PW_CYC > 255 || HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_param_chk
    $error("lcd_nibble_tx: timing parameters out of range");
  end

  localparam logic [LCD_PHASE_W-1:0] SETUP_V = LCD_PHASE_W'(SETUP_CYC);
  localparam logic [LCD_PHASE_W-1:0] PW_V    = LCD_PHASE_W'(PW_CYC);
  localparam logic [LCD_PHASE_W-1:0] HOLD_V  = LCD_PHASE_W'(HOLD_CYC);

  lcd_state_t               r_state, w_next_state;
  logic [LCD_DELAY_W-1:0]   r_delay;
  logic                     w_accept;
  logic                     w_ph_load, w_ph_en, w_ph_exp;
  logic [LCD_PHASE_W-1:0]   w_ph_val;
  logic                     w_dl_load, w_dl_en, w_dl_exp;
  logic                     w_e_next, w_done_next;

  lcd_cycle_timer #(.W(LCD_PHASE_W)) u_phase_timer (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (w_ph_load),
    .i_value   (w_ph_val),
    .i_en      (w_ph_en),
    .o_expired (w_ph_exp)
  );

  lcd_cycle_timer #(.W(LCD_DELAY_W)) u_delay_timer (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (w_dl_load),
    .i_value   (r_delay),
    .i_en      (w_dl_en),
    .o_expired (w_dl_exp)
  );

  assign w_ph_en = (r_state == ST_SETUP) || (r_state == ST_PULSE) || (r_state == ST_HOLD);
  assign w_dl_en = (r_state == ST_WAIT);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state, timer loads and next values of the registered pin outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_ph_load    = 1'b0;
    w_ph_val     = SETUP_V;
    w_dl_load    = 1'b0;
    w_e_next     = 1'b0;
    w_done_next  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (sendCommand) begin
          w_accept     = 1'b1;
          w_ph_load    = 1'b1;
          w_ph_val     = SETUP_V;
          w_next_state = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_ph_exp) begin
          w_e_next     = 1'b1;
          w_ph_load    = 1'b1;
          w_ph_val     = PW_V;
          w_next_state = ST_PULSE;
        end
      end
      ST_PULSE: begin
        w_e_next = 1'b1;
        if (w_ph_exp) begin
          w_e_next     = 1'b0;
          w_ph_load    = 1'b1;
          w_ph_val     = HOLD_V;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_ph_exp) begin
          // A zero delay skips WAIT entirely and completes now.
          if (r_delay == '0) begin
            w_done_next  = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_dl_load    = 1'b1;
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_dl_exp) begin
          w_done_next  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Registered pins plus the command/delay latch, captured only on accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      LCD_D       <= '0;
      LCD_E       <= 1'b0;
      commandDone <= 1'b0;
      r_delay     <= '0;
    end else begin
      LCD_E       <= w_e_next;
      commandDone <= w_done_next;
      if (w_accept) begin
        LCD_D   <= command;
        r_delay <= commandDelay;
      end
    end
  end

`ifdef LCD_NIBBLE_TX_BUSY_EN
  assign busy = (r_state != ST_IDLE);
`endif

endmodule
